// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART TX frame sequencer; break generation built only with UART_TX_BREAK_EN
module uart_tx_frame_ctrl #(
   parameter int DATA_W        = 8,
   parameter int MIN_IDLE_BITS = 0
) (
   input  logic                      i_clk,
   input  logic                      i_resetn,
   input  logic                      i_baud_tick,
   input  logic                      i_data_valid,
   input  logic                      i_par_en,
   input  logic                      i_par_odd,
   input  logic                      i_stop2,
`ifdef UART_TX_BREAK_EN
   input  logic                      i_break,
`endif
   output logic                      o_latch_en,
   output logic                      o_ser_en,
   output logic [$clog2(DATA_W)-1:0] o_bit_idx,
   output logic                      o_par_odd,
   output logic [2:0]                o_mux_sel,
   output logic                      o_busy,
   output logic                      o_done
);

   localparam int              IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam bit              HAS_GAP  = (MIN_IDLE_BITS > 0);
   localparam logic [3:0]      GAP_LAST = HAS_GAP ? 4'(MIN_IDLE_BITS - 1) : 4'd0;

   localparam logic [2:0] MUX_MARK  = 3'd0;
   localparam logic [2:0] MUX_START = 3'd1;
   localparam logic [2:0] MUX_DATA  = 3'd2;
   localparam logic [2:0] MUX_PAR   = 3'd3;
`ifdef UART_TX_BREAK_EN
   localparam logic [2:0] MUX_BRK   = 3'd4;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARM,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK,
      S_BRK_MARK
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             par_en_q, par_en_d;
   logic             par_odd_q, par_odd_d;
   logic             stop2_q, stop2_d;
   logic             latch_q, latch_d;
   logic             accept;

   assign o_latch_en = latch_q;
   assign o_bit_idx  = idx_q;
   assign o_par_odd  = par_odd_q;

   // State, bit index, shared tick counter and the per-frame config snapshot
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         latch_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         stop2_q   <= stop2_d;
         latch_q   <= latch_d;
      end
   end

   // Next-state and line-control decode; every line bit advances on a baud tick
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      stop2_d   = stop2_q;
      latch_d   = 1'b0;
      accept    = 1'b0;
      o_ser_en  = 1'b0;
      o_mux_sel = MUX_MARK;
      o_busy    = 1'b1;
      o_done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            o_busy = 1'b0;
`ifdef UART_TX_BREAK_EN
            if (i_break) begin
               state_d = S_BREAK;
            end else
`endif
            if (i_data_valid) begin
               accept = 1'b1;
            end
         end
         S_ARM: begin
            if (i_baud_tick) state_d = S_START;
         end
         S_START: begin
            o_mux_sel = MUX_START;
            if (i_baud_tick) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            o_mux_sel = MUX_DATA;
            if (i_baud_tick) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  o_ser_en = 1'b1;
                  idx_d    = idx_q + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            o_mux_sel = MUX_PAR;
            if (i_baud_tick) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end
         end
         S_STOP: begin
            if (i_baud_tick) begin
               if (stop2_q && (cnt_q == 4'd0)) begin
                  cnt_d = 4'd1;
               end else begin
                  o_done = 1'b1;
                  cnt_d  = '0;
                  if (HAS_GAP) begin
                     state_d = S_GAP;
                  end else if (i_data_valid) begin
                     // back-to-back frame: re-arm without dropping busy
                     accept = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_GAP: begin
            if (i_baud_tick) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            o_mux_sel = MUX_BRK;
            if (!i_break) begin
               state_d = S_BRK_MARK;
               cnt_d   = '0;
            end
         end
         S_BRK_MARK: begin
            // two mark bit-periods after a break before the line is reusable
            if (i_baud_tick) begin
               if (cnt_q == 4'd1) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         state_d   = S_ARM;
         latch_d   = 1'b1;
         par_en_d  = i_par_en;
         par_odd_d = i_par_odd;
         stop2_d   = i_stop2;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - directed bench for uart_tx_frame_ctrl (4 parameter sets)
module tb_uart_tx_frame_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       baud_tick = 1'b0;
   logic [3:0] valid = 4'b0;
   logic       par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0, brk = 1'b0;

   logic       lat [4];
   logic       ser [4];
   logic       podd [4];
   logic [2:0] mux [4];
   logic       busy [4];
   logic       done [4];
   logic [2:0] idx0, idx1, idx5;
   logic [3:0] idx9;

   logic [1:0] sel = 2'd0;
   logic       o_lat, o_ser, o_podd, o_busy, o_done;
   logic [2:0] o_mux;
   logic [3:0] o_idx;

   int total = 0;
   int bad = 0;

   int n_lat, n_ser, n_done, done_t, ft, ovl, idx_bad, dcnt, par_at_done;
   bit started, armed;
   logic [63:0] mseq;
   logic [10:0] snap;
   int tcnt = 0;

   always #5 clk = ~clk;

   // free-running baud tick, one clk wide every 16 clocks
   always @(negedge clk) begin
      tcnt = (tcnt == 15) ? 0 : tcnt + 1;
      baud_tick = (tcnt == 0);
   end

   uart_tx_frame_ctrl #(.DATA_W(8), .MIN_IDLE_BITS(0)) u_w8 (
      .i_clk(clk), .i_resetn(resetn), .i_baud_tick(baud_tick), .i_data_valid(valid[0]),
      .i_par_en(par_en), .i_par_odd(par_odd), .i_stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .i_break(brk),
`endif
      .o_latch_en(lat[0]), .o_ser_en(ser[0]), .o_bit_idx(idx0), .o_par_odd(podd[0]),
      .o_mux_sel(mux[0]), .o_busy(busy[0]), .o_done(done[0]));

   uart_tx_frame_ctrl #(.DATA_W(8), .MIN_IDLE_BITS(2)) u_gap (
      .i_clk(clk), .i_resetn(resetn), .i_baud_tick(baud_tick), .i_data_valid(valid[1]),
      .i_par_en(par_en), .i_par_odd(par_odd), .i_stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .i_break(1'b0),
`endif
      .o_latch_en(lat[1]), .o_ser_en(ser[1]), .o_bit_idx(idx1), .o_par_odd(podd[1]),
      .o_mux_sel(mux[1]), .o_busy(busy[1]), .o_done(done[1]));

   uart_tx_frame_ctrl #(.DATA_W(5), .MIN_IDLE_BITS(0)) u_w5 (
      .i_clk(clk), .i_resetn(resetn), .i_baud_tick(baud_tick), .i_data_valid(valid[2]),
      .i_par_en(par_en), .i_par_odd(par_odd), .i_stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .i_break(1'b0),
`endif
      .o_latch_en(lat[2]), .o_ser_en(ser[2]), .o_bit_idx(idx5), .o_par_odd(podd[2]),
      .o_mux_sel(mux[2]), .o_busy(busy[2]), .o_done(done[2]));

   uart_tx_frame_ctrl #(.DATA_W(9), .MIN_IDLE_BITS(0)) u_w9 (
      .i_clk(clk), .i_resetn(resetn), .i_baud_tick(baud_tick), .i_data_valid(valid[3]),
      .i_par_en(par_en), .i_par_odd(par_odd), .i_stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .i_break(1'b0),
`endif
      .o_latch_en(lat[3]), .o_ser_en(ser[3]), .o_bit_idx(idx9), .o_par_odd(podd[3]),
      .o_mux_sel(mux[3]), .o_busy(busy[3]), .o_done(done[3]));

   // view of the instance currently under test
   always_comb begin
      o_lat  = lat[sel];
      o_ser  = ser[sel];
      o_podd = podd[sel];
      o_mux  = mux[sel];
      o_busy = busy[sel];
      o_done = done[sel];
      case (sel)
         2'd0:    o_idx = {1'b0, idx0};
         2'd1:    o_idx = {1'b0, idx1};
         2'd2:    o_idx = {1'b0, idx5};
         default: o_idx = idx9;
      endcase
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // one valid pulse, then watch the frame; optional mid-frame valid/par_en poke and reset
   task automatic watch(input int max_cyc, input int poke_at, input int rst_at);
      n_lat = 0; n_ser = 0; n_done = 0; done_t = -1; ft = 0; ovl = 0;
      idx_bad = 0; dcnt = 0; par_at_done = 0; started = 0; armed = 0;
      mseq = '0; snap = '1;
      valid[sel] = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         step();
         valid[sel] = 1'b0;
         if (o_lat) begin n_lat++; started = 1; end
         if (o_lat && o_ser) ovl++;
         if (o_ser) n_ser++;
         if (started && baud_tick && n_done == 0) begin
            if (!armed) begin
               armed = 1;
            end else begin
               ft++;
               mseq = {mseq[60:0], o_mux};
               if (o_mux == 3'd2) begin
                  if (o_idx != 4'(dcnt)) idx_bad++;
                  dcnt++;
               end else if (o_idx != 4'd0) begin
                  idx_bad++;
               end
               if (poke_at > 0 && ft == poke_at) begin
                  valid[sel] = 1'b1;
                  par_en = ~par_en;
               end
               if (rst_at > 0 && ft == rst_at) begin
                  resetn = 1'b0;
                  #1;
                  snap = {o_lat, o_ser, o_done, o_busy, o_podd, o_mux, o_idx};
                  return;
               end
            end
         end
         if (o_done) begin n_done++; done_t = ft; par_at_done = int'(o_podd); end
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         total++;
         if ({o_lat, o_ser, o_done, o_busy, o_podd, o_mux, o_idx} !== 11'd0)
            begin bad++; $display("FAIL reset_outputs inst=%0d got=%b want=0", s, {o_lat, o_ser, o_done, o_busy, o_podd, o_mux, o_idx}); end
      end
      sel = 2'd0;
   endtask

   task automatic test_basic();
      sel = 2'd0; par_en = 0; par_odd = 0; stop2 = 0;
      watch(300, 0, 0);
      total++; if (n_lat !== 1) begin bad++; $display("FAIL t1_latch got=%0d want=1", n_lat); end
      total++; if (n_ser !== 7) begin bad++; $display("FAIL t1_ser_en got=%0d want=7", n_ser); end
      total++; if (n_done !== 1 || done_t !== 10) begin bad++; $display("FAIL t1_done got=%0d@%0d want=1@10", n_done, done_t); end
      total++; if (mseq !== 64'o1222222220) begin bad++; $display("FAIL t1_mux got=%o want=%o", mseq, 64'o1222222220); end
      total++; if (idx_bad !== 0 || dcnt !== 8) begin bad++; $display("FAIL t1_bit_idx got=%0d/%0d want=0/8", idx_bad, dcnt); end
      total++; if (ovl !== 0) begin bad++; $display("FAIL t1_overlap got=%0d want=0", ovl); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t1_busy_after got=%b want=0", o_busy); end
   endtask

   task automatic test_parity();
      sel = 2'd0; par_en = 1; par_odd = 1; stop2 = 1;
      watch(300, 0, 0);
      par_en = 0; par_odd = 0; stop2 = 0;
      total++; if (n_ser !== 7) begin bad++; $display("FAIL t2_ser_en got=%0d want=7", n_ser); end
      total++; if (n_done !== 1 || done_t !== 12) begin bad++; $display("FAIL t2_done got=%0d@%0d want=1@12", n_done, done_t); end
      total++; if (mseq !== 64'o122222222300) begin bad++; $display("FAIL t2_mux got=%o want=%o", mseq, 64'o122222222300); end
      total++; if (par_at_done !== 1) begin bad++; $display("FAIL t2_par_odd got=%0d want=1", par_at_done); end
   endtask

   task automatic test_ignore();
      sel = 2'd0; par_en = 0; par_odd = 0; stop2 = 0;
      watch(300, 5, 0);
      par_en = 0;
      total++; if (n_lat !== 1) begin bad++; $display("FAIL t3_latch got=%0d want=1", n_lat); end
      total++; if (n_done !== 1 || done_t !== 10) begin bad++; $display("FAIL t3_done got=%0d@%0d want=1@10", n_done, done_t); end
      total++; if (mseq !== 64'o1222222220) begin bad++; $display("FAIL t3_mux got=%o want=%o", mseq, 64'o1222222220); end
   endtask

   task automatic test_back_to_back();
      int c_done, c_lat2, nl, low, idle;
      sel = 2'd0; c_done = -1; c_lat2 = -1; nl = 0; low = 0; idle = 0;
      valid[0] = 1'b1;
      for (int c = 0; c < 600; c++) begin
         step();
         if (o_lat) begin nl++; if (nl == 2) c_lat2 = c; end
         if (nl >= 1 && c_lat2 < 0 && !o_busy) low++;
         if (o_done && c_done < 0) c_done = c;
         if (nl == 2) break;
      end
      valid[0] = 1'b0;
      total++; if (nl !== 2 || c_done < 0 || c_lat2 !== c_done + 1) begin bad++; $display("FAIL t4_b2b_latch got=%0d@%0d done@%0d want=2@done+1", nl, c_lat2, c_done); end
      total++; if (low !== 0) begin bad++; $display("FAIL t4_busy_gap got=%0d want=0", low); end
      for (int c = 0; c < 400; c++) begin
         step();
         if (!o_busy) begin idle = 1; break; end
      end
      total++; if (idle !== 1) begin bad++; $display("FAIL t4_second_frame_end got=%0d want=1", idle); end
   endtask

   task automatic test_gap();
      int c_done, gt, prev_tick, dropped;
      sel = 2'd1; c_done = -1; gt = 0; prev_tick = 0; dropped = 0;
      valid[1] = 1'b1;
      for (int c = 0; c < 500; c++) begin
         step();
         valid[1] = 1'b0;
         if (c_done >= 0 && !o_busy) begin dropped = 1; break; end
         prev_tick = int'(baud_tick);
         if (c_done >= 0 && baud_tick) gt++;
         if (o_done && c_done < 0) c_done = c;
      end
      total++; if (c_done < 0 || dropped !== 1) begin bad++; $display("FAIL t4_gap_end got=%0d want=1", dropped); end
      total++; if (gt !== 2 || prev_tick !== 1) begin bad++; $display("FAIL t4_gap_ticks got=%0d/%0d want=2/1", gt, prev_tick); end
      sel = 2'd0;
   endtask

   task automatic test_reset_mid();
      int act;
      sel = 2'd0; par_en = 1; par_odd = 1; stop2 = 0; act = 0;
      watch(300, 0, 6);
      par_en = 0; par_odd = 0;
      total++; if (ft !== 6) begin bad++; $display("FAIL t5_reached_bit4 got=%0d want=6", ft); end
      total++; if (snap !== 11'd0) begin bad++; $display("FAIL t5_reset_outputs got=%b want=0", snap); end
      step();
      resetn = 1'b1;
      for (int c = 0; c < 64; c++) begin
         step();
         if (o_lat || o_ser || o_done || o_busy || o_mux != 3'd0 || o_idx != 4'd0) act++;
      end
      total++; if (act !== 0) begin bad++; $display("FAIL t5_quiet got=%0d want=0", act); end
   endtask

   task automatic test_widths();
      sel = 2'd2; par_en = 0; stop2 = 0;
      watch(300, 0, 0);
      total++; if (n_ser !== 4) begin bad++; $display("FAIL t6_w5_ser_en got=%0d want=4", n_ser); end
      total++; if (done_t !== 7) begin bad++; $display("FAIL t6_w5_done got=%0d want=7", done_t); end
      total++; if (mseq !== 64'o1222220) begin bad++; $display("FAIL t6_w5_mux got=%o want=%o", mseq, 64'o1222220); end
      sel = 2'd3; stop2 = 1;
      watch(300, 0, 0);
      stop2 = 0;
      total++; if (n_ser !== 8) begin bad++; $display("FAIL t6_w9_ser_en got=%0d want=8", n_ser); end
      total++; if (done_t !== 12) begin bad++; $display("FAIL t6_w9_done got=%0d want=12", done_t); end
      total++; if (mseq !== 64'o122222222200) begin bad++; $display("FAIL t6_w9_mux got=%o want=%o", mseq, 64'o122222222200); end
      total++; if (idx_bad !== 0 || dcnt !== 9) begin bad++; $display("FAIL t6_w9_bit_idx got=%0d/%0d want=0/9", idx_bad, dcnt); end
      sel = 2'd0;
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      int nt, mt, bad4, nl, idle;
      sel = 2'd0; nt = 0; mt = 0; bad4 = 0; nl = 0; idle = 0;
      brk = 1'b1; valid[0] = 1'b1;
      for (int c = 0; c < 200; c++) begin
         step();
         valid[0] = 1'b0;
         if (o_lat) nl++;
         if (o_mux !== 3'd4 || !o_busy) bad4++;
         if (baud_tick) nt++;
         if (nt == 5) break;
      end
      brk = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (!o_busy) begin idle = 1; break; end
         if (o_mux !== 3'd0) bad4++;
         if (baud_tick) mt++;
      end
      total++; if (bad4 !== 0 || nl !== 0) begin bad++; $display("FAIL brk_line got=%0d/%0d want=0/0", bad4, nl); end
      total++; if (idle !== 1 || mt !== 2) begin bad++; $display("FAIL brk_mark_ticks got=%0d/%0d want=1/2", idle, mt); end
   endtask
`endif

   initial begin
      resetn = 1'b0;
      repeat (3) step();
      test_reset();
      resetn = 1'b1;
      step();
      test_basic();
      test_parity();
      test_ignore();
      test_back_to_back();
      test_gap();
      test_reset_mid();
      test_widths();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
